// File: rtl/main_mem_model.sv
// main_mem_model: word-addressed backing store answering cache requests after LATENCY cycles.
// Define MEM_STATS_EN to build the completed read/write counters on oRD_CNT/oWR_CNT.
module main_mem_model #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 8,
    parameter int LATENCY = 3
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [ADDR_W-1:0] cache2mem_addr,
    input  logic [DATA_W-1:0] cache2mem_data,
    input  logic              cache2mem_MemWrite,
    input  logic              cache2mem_MemRead,
    output logic [DATA_W-1:0] mem2cache_data_in,
    output logic              mem2cache_ready,
    output logic              oERR,
    output logic [31:0]       oRD_CNT,
    output logic [31:0]       oWR_CNT
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_q, wr_d, both_q, both_d;
    logic                ready_q, ready_d, err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   mem_q [2**DEPTH_W];
    logic [DEPTH_W-1:0]  idx;
    logic                bad_addr, illegal;

    assign idx      = addr_q[DEPTH_W+1:2];
    assign bad_addr = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:DEPTH_W+2]);
    assign illegal  = bad_addr || both_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        both_d  = both_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: if (cache2mem_MemRead || cache2mem_MemWrite) begin
                addr_d  = cache2mem_addr;
                data_d  = cache2mem_data;
                wr_d    = cache2mem_MemWrite;
                both_d  = cache2mem_MemRead && cache2mem_MemWrite;
                cnt_d   = 4'(LATENCY - 1);
                state_d = BUSY;
            end
            // Response registers load on the edge entering RESP so outputs stay registered.
            BUSY: if (cnt_q == 4'd0) begin
                state_d = RESP;
                ready_d = 1'b1;
                err_d   = illegal;
                rdata_d = (!wr_q && !illegal) ? mem_q[idx] : '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is never reset; a write lands on the edge leaving RESP unless reset is active.
    always_ff @(posedge iCLK) begin
        if (!iRST && state_q == RESP && wr_q && !bad_addr)
            mem_q[idx] <= data_q;
    end

    assign mem2cache_ready   = ready_q;
    assign mem2cache_data_in = rdata_q;
    assign oERR              = err_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == RESP) begin
            rd_cnt_q <= rd_cnt_q + {31'd0, !wr_q};
            wr_cnt_q <= wr_cnt_q + {31'd0, wr_q};
        end
    end

    assign oRD_CNT = rd_cnt_q;
    assign oWR_CNT = wr_cnt_q;
`else
    assign oRD_CNT = '0;
    assign oWR_CNT = '0;
`endif
endmodule

// File: tb/tb_main_mem_model.sv
// tb_main_mem_model: directed accesses checked against a word-array model of the memory.
module tb_main_mem_model;
    localparam int LAT = 3;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [31:0] cache2mem_addr = '0;
    logic [31:0] cache2mem_data = '0;
    logic        cache2mem_MemWrite = 1'b0;
    logic        cache2mem_MemRead = 1'b0;
    logic [31:0] mem2cache_data_in;
    logic        mem2cache_ready;
    logic        oERR;
    logic [31:0] oRD_CNT, oWR_CNT;

    main_mem_model #(.LATENCY(LAT)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .cache2mem_addr(cache2mem_addr), .cache2mem_data(cache2mem_data),
        .cache2mem_MemWrite(cache2mem_MemWrite), .cache2mem_MemRead(cache2mem_MemRead),
        .mem2cache_data_in(mem2cache_data_in), .mem2cache_ready(mem2cache_ready),
        .oERR(oERR), .oRD_CNT(oRD_CNT), .oWR_CNT(oWR_CNT)
    );

    always #5 iCLK = ~iCLK;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic [31:0] model [256];
    bit          active = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;
    int          exp_rd = 0, exp_wr = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every cycle: ready exactly in the cycle after edge acc+LAT, data/err zero elsewhere.
    always @(negedge iCLK) begin
        logic er;
        er = active && (cyc == acc_cyc + LAT);
        chk("ready", {31'd0, mem2cache_ready}, {31'd0, er});
        chk("data", mem2cache_data_in, er ? exp_data : 32'd0);
        chk("err", {31'd0, oERR}, {31'd0, er && exp_err});
    end

    task automatic access(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w,
                          input logic [31:0] lit_data, input bit lit_err, input string nm);
        bit bad;
        int n;
        @(negedge iCLK);
        bad      = (a % 4 != 0) || (a >= 1024);
        exp_err  = bad || (r && w);
        exp_data = (!w && !exp_err) ? model[a / 4] : 32'd0;
        acc_cyc  = cyc + 1;
        active   = 1;
        cache2mem_addr = a;
        cache2mem_data = d;
        cache2mem_MemRead  = r;
        cache2mem_MemWrite = w;
        n = 0;
        while (!mem2cache_ready && n < 40) begin
            @(negedge iCLK);
            n++;
        end
        if (!mem2cache_ready) begin
            mismatched++;
            compared++;
            $display("FAIL %s timeout: no ready within 40 cycles", nm);
        end else begin
            chk({nm, " latency"}, cyc - (acc_cyc - 1) - 1, 32'd3);
            chk({nm, " value"}, mem2cache_data_in, lit_data);
            chk({nm, " errflag"}, {31'd0, oERR}, {31'd0, lit_err});
        end
        if (w && !bad) model[a / 4] = d;
        if (w) exp_wr++; else exp_rd++;
        @(negedge iCLK);
        @(negedge iCLK);
        cache2mem_MemRead  = 0;
        cache2mem_MemWrite = 0;
        active = 0;
`ifdef MEM_STATS_EN
        chk({nm, " rdcnt"}, oRD_CNT, exp_rd);
        chk({nm, " wrcnt"}, oWR_CNT, exp_wr);
`else
        chk({nm, " rdcnt"}, oRD_CNT, 32'd0);
        chk({nm, " wrcnt"}, oWR_CNT, 32'd0);
`endif
    endtask

    initial begin
        repeat (2) @(negedge iCLK);
        iRST = 0;
        access(32'h04, 32'd234, 0, 1, 32'd0, 0, "wr04_234");
        access(32'h04, 32'd0, 1, 0, 32'd234, 0, "rd04_234");
        access(32'h04, 32'd5, 0, 1, 32'd0, 0, "wr04_5");
        access(32'h08, 32'd10, 0, 1, 32'd0, 0, "wr08_10");
        access(32'h04, 32'd0, 1, 0, 32'd5, 0, "rd04_5");
        access(32'h08, 32'd0, 1, 0, 32'd10, 0, "rd08_10");
        access(32'h84, 32'd20, 0, 1, 32'd0, 0, "wr84_20");
        access(32'h84, 32'd0, 1, 0, 32'd20, 0, "rd84_20");
        access(32'h04, 32'd0, 1, 0, 32'd5, 0, "rd04_again");
        access(32'h00, 32'h11, 0, 1, 32'd0, 0, "wr00_11");
        access(32'h06, 32'd0, 1, 0, 32'd0, 1, "rd06_misal");
        access(32'h400, 32'd99, 0, 1, 32'd0, 1, "wr400_oor");
        access(32'h00, 32'd0, 1, 0, 32'h11, 0, "rd00_alias");
        access(32'h20, 32'd9, 1, 1, 32'd0, 1, "both20_9");
        access(32'h20, 32'd0, 1, 0, 32'd9, 0, "rd20_9");
        access(32'h10, 32'h33, 0, 1, 32'd0, 0, "wr10_33");
        // Abort a write of 77 to 0x10 with reset while the access is in BUSY.
        @(negedge iCLK);
        cache2mem_addr = 32'h10;
        cache2mem_data = 32'd77;
        cache2mem_MemWrite = 1;
        @(posedge iCLK);
        @(posedge iCLK);
        #2 iRST = 1;
        cache2mem_MemWrite = 0;
        #1;
        chk("rst ready", {31'd0, mem2cache_ready}, 32'd0);
        chk("rst data", mem2cache_data_in, 32'd0);
        chk("rst rdcnt", oRD_CNT, 32'd0);
        chk("rst wrcnt", oWR_CNT, 32'd0);
        exp_rd = 0;
        exp_wr = 0;
        repeat (2) @(negedge iCLK);
        iRST = 0;
        access(32'h10, 32'd0, 1, 0, 32'h33, 0, "rd10_old");
        repeat (3) @(negedge iCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
